psum_accumulator: RTL and testbench
===================================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter LANES, default 64, number of parallel partial-sum lanes.
REQ-002 SHALL have parameter IN_W, default 8, signed input partial-sum width.
REQ-003 SHALL have parameter ACC_W, default 16, signed accumulator and output width; legal range IN_W+1 to 24.
REQ-004 SHALL have parameter BEATS, default 9, input beats per accumulation group; legal range 2 to 255.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port data_in_valid, input, 1, qualifies data_in for one beat.
REQ-008 SHALL have port data_in[LANES-1:0], input, IN_W each, signed partial sums from the upstream 2-way adder stage.
REQ-009 SHALL have port clear, input, 1, synchronous abort of the current group.
REQ-010 SHALL have port acc_out_valid, output, 1, single-cycle pulse marking a completed group.
REQ-011 SHALL have port acc_out[LANES-1:0], output, ACC_W each, signed accumulated results.
REQ-012 SHALL have port acc_sat, output, 1, set if any lane saturated during the reported group.
REQ-013 SHALL have port busy, output, 1, high while a group is partially accumulated (beat count 1..BEATS-1).

Function
REQ-014 SHALL keep a beat counter cnt (0..BEATS-1) and per-lane accumulators acc[k] of ACC_W bits.
REQ-015 SHALL implement two states: IDLE (cnt=0, acc cleared) and ACCUM (cnt>=1).
REQ-016 SHALL, on a valid beat in IDLE, load acc[k] = sign-extended data_in[k], set cnt=1 and enter ACCUM.
REQ-017 SHALL, on a valid beat in ACCUM with cnt<BEATS-1, set acc[k] = sat(acc[k]+data_in[k]) and increment cnt.
REQ-018 SHALL, on the valid beat with cnt=BEATS-1, compute the final sum, register it into acc_out, pulse acc_out_valid the next cycle, and return to IDLE.
REQ-019 SHALL give a latency of 1 cycle from the final beat's clock edge to acc_out_valid high.
REQ-020 SHALL hold state unchanged on cycles with data_in_valid low; non-consecutive beats are legal.
REQ-021 SHALL accept back-to-back groups with no bubble: the cycle after a final beat may carry beat 1 of the next group.
REQ-022 SHALL saturate each addition to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and never wrap.
REQ-023 SHALL set a sticky group flag when any lane saturates, copy it to acc_sat with acc_out, and clear it on group start.
REQ-024 SHALL hold acc_out and acc_sat stable until the next completed group overwrites them.
REQ-025 SHALL make clear take priority over data_in_valid in the same cycle: cnt=0, acc=0, sticky flag=0, beat discarded, no acc_out_valid, acc_out unchanged.
REQ-026 SHALL ignore clear in IDLE except for discarding a same-cycle beat.
REQ-027 SHALL drive busy combinationally as (cnt != 0).

Reset
REQ-028 SHALL, while rstn is low, force cnt=0, all acc=0, sticky flag=0, acc_out all 0, acc_out_valid=0, acc_sat=0, busy=0.
REQ-029 SHALL, on reset asserted mid-group, discard the partial group; the first valid beat after release starts a new group.

Verification
REQ-030 SHALL pass: 9 consecutive beats with all lanes = 3 -> one acc_out_valid pulse 1 cycle after beat 9, all acc_out = 27, acc_sat = 0.
REQ-031 SHALL pass: 9 beats with valid gaps of 0-3 cycles, lane k = k-32 -> acc_out[k] = 9*(k-32), exactly one pulse.
REQ-032 SHALL pass: two groups back-to-back (18 consecutive beats, group A all 1, group B all -2) -> pulses at cycles 10 and 19, values 9 then -18.
REQ-033 SHALL pass, with ACC_W=9: 9 beats of 127 on lane 0 -> acc_out[0] = 255, acc_sat = 1; the next group of all 0 reports acc_sat = 0.
REQ-034 SHALL pass: clear asserted with beat 5 of a group -> no pulse, busy drops the next cycle, and a fresh 9 beats of 1 yield 9.
REQ-035 SHALL pass: rstn pulsed low after beat 4 -> all outputs 0 asynchronously, and the next 9 beats of 2 yield 18.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: per-lane saturating accumulation of BEATS signed
// partial-sum beats, reporting one result vector per completed group.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   data_in_valid  qualifies data_in for one beat
//   data_in        LANES signed IN_W-bit partial sums
//   clear          synchronous abort of the current group (wins over a beat)
//   acc_out_valid  one-cycle pulse when a group completes
//   acc_out        LANES signed ACC_W-bit results, held until next group
//   acc_sat        some lane saturated during the reported group
//   busy           a group is partially accumulated
module psum_accumulator #(
   parameter int LANES = 64,
   parameter int IN_W  = 8,
   parameter int ACC_W = 16,
   parameter int BEATS = 9
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    data_in_valid,
   input  logic signed [IN_W-1:0]  data_in [LANES-1:0],
   input  logic                    clear,
   output logic                    acc_out_valid,
   output logic signed [ACC_W-1:0] acc_out [LANES-1:0],
   output logic                    acc_sat,
   output logic                    busy
);

   localparam int CW = (BEATS > 2) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
   localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_nx;
   logic                    load;
   logic                    add;
   logic                    fin;
   logic                    sticky;
   logic                    any_sat;
   logic signed [ACC_W-1:0] acc  [LANES-1:0];
   logic signed [ACC_W-1:0] sum  [LANES-1:0];
   logic [ACC_W:0]          wide [LANES-1:0];
   logic [LANES-1:0]        lane_sat;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      load     = 1'b0;
      add      = 1'b0;
      fin      = 1'b0;
      if (clear) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else if (data_in_valid) begin
         unique case (state)
            IDLE: begin
               state_nx = ACCUM;
               cnt_nx   = CW'(1);
               load     = 1'b1;
            end
            ACCUM: begin
               if (cnt == LAST) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
                  fin      = 1'b1;
               end else begin
                  cnt_nx = cnt + CW'(1);
                  add    = 1'b1;
               end
            end
         endcase
      end
   end

   // One extra bit of headroom: overflow shows as the top two bits differing.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         wide[k] = {acc[k][ACC_W-1], acc[k]}
                 + {{(ACC_W+1-IN_W){data_in[k][IN_W-1]}}, data_in[k]};
         lane_sat[k] = wide[k][ACC_W] ^ wide[k][ACC_W-1];
         if (lane_sat[k])
            sum[k] = wide[k][ACC_W] ? MINV : MAXV;
         else
            sum[k] = wide[k][ACC_W-1:0];
      end
   end

   assign any_sat = |lane_sat;
   assign busy    = (cnt != '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < LANES; k++) begin
            acc[k]     <= '0;
            acc_out[k] <= '0;
         end
         sticky        <= 1'b0;
         acc_sat       <= 1'b0;
         acc_out_valid <= 1'b0;
      end else begin
         acc_out_valid <= fin;
         if (clear) begin
            for (int k = 0; k < LANES; k++)
               acc[k] <= '0;
            sticky <= 1'b0;
         end else if (load) begin
            for (int k = 0; k < LANES; k++)
               acc[k] <= {{(ACC_W-IN_W){data_in[k][IN_W-1]}}, data_in[k]};
            sticky <= 1'b0;
         end else if (add) begin
            for (int k = 0; k < LANES; k++)
               acc[k] <= sum[k];
            sticky <= sticky | any_sat;
         end else if (fin) begin
            for (int k = 0; k < LANES; k++) begin
               acc_out[k] <= sum[k];
               acc[k]     <= '0;
            end
            acc_sat <= sticky | any_sat;
            sticky  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: scoreboard bench for psum_accumulator, with a
// default-size instance and a narrow ACC_W=9 instance for saturation.
module tb_psum_accumulator;

   localparam int L = 64;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic valid = 1'b0;
   logic clear = 1'b0;
   logic signed [7:0]  din  [L-1:0];
   logic signed [15:0] aout [L-1:0];
   logic ov, sat, busy;

   logic valid2 = 1'b0;
   logic signed [7:0] din2  [3:0];
   logic signed [8:0] aout2 [3:0];
   logic ov2, sat2, busy2;

   int checks = 0;
   int failures = 0;
   int pcyc = 0;

   int qb[$];
   bit qr[$];
   bit qs[$];
   int qd[$];
   int q2a[$];
   int q2b[$];
   bit q2s[$];
   int q2d[$];

   psum_accumulator dut (
      .clk(clk), .rstn(rstn), .data_in_valid(valid), .data_in(din),
      .clear(clear), .acc_out_valid(ov), .acc_out(aout),
      .acc_sat(sat), .busy(busy)
   );

   psum_accumulator #(.LANES(4), .ACC_W(9)) dut2 (
      .clk(clk), .rstn(rstn), .data_in_valid(valid2), .data_in(din2),
      .clear(1'b0), .acc_out_valid(ov2), .acc_out(aout2),
      .acc_sat(sat2), .busy(busy2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) pcyc++;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   int b, d, bad, e;
   bit r, s;

   always @(negedge clk) begin
      if (rstn && ov) begin
         if (qb.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            b = qb.pop_front();
            r = qr.pop_front();
            s = qs.pop_front();
            d = qd.pop_front();
            bad = 0;
            for (int k = 0; k < L; k++) begin
               e = r ? b * (k - 32) : b;
               if (int'(aout[k]) != e) begin
                  bad++;
                  if (bad == 1)
                     chk("lane_value", int'(aout[k]), e);
               end
            end
            chk("pulse_cycle", pcyc, d);
            chk("lanes_bad", bad, 0);
            chk("acc_sat", int'(sat), int'(s));
         end
      end
   end

   always @(negedge clk) begin
      if (rstn && ov2) begin
         if (q2a.size() == 0) begin
            chk("d2_unexpected_pulse", 1, 0);
         end else begin
            chk("d2_pulse_cycle", pcyc, q2d.pop_front());
            chk("d2_lane0", int'(aout2[0]), q2a.pop_front());
            chk("d2_lane1", int'(aout2[1]), q2b.pop_front());
            chk("d2_acc_sat", int'(sat2), int'(q2s.pop_front()));
         end
      end
   end

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         valid  = 1'b0;
         clear  = 1'b0;
         valid2 = 1'b0;
      end
   endtask

   task automatic beat(int v, bit ramp, bit clr);
      @(negedge clk);
      valid  = 1'b1;
      clear  = clr;
      valid2 = 1'b0;
      for (int k = 0; k < L; k++)
         din[k] = 8'(ramp ? k - 32 : v);
   endtask

   // Nine beats; gap pattern (3*i)%4 gives idle gaps of 0..3 when gapped.
   task automatic group(int v, bit ramp, bit gapped, int expv, bit esat);
      for (int i = 0; i < 9; i++) begin
         if (gapped && ((3 * i) % 4) != 0)
            idle((3 * i) % 4);
         beat(v, ramp, 1'b0);
         if (i == 8) begin
            qb.push_back(expv);
            qr.push_back(ramp);
            qs.push_back(esat);
            qd.push_back(pcyc + 1);
         end
      end
   endtask

   task automatic group2(int v0, int v1, int e0, int e1, bit esat);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         valid  = 1'b0;
         valid2 = 1'b1;
         din2[0] = 8'(v0);
         din2[1] = 8'(v1);
         din2[2] = 8'sd0;
         din2[3] = 8'sd0;
      end
      q2a.push_back(e0);
      q2b.push_back(e1);
      q2s.push_back(esat);
      q2d.push_back(pcyc + 1);
   endtask

   initial begin
      for (int k = 0; k < L; k++) din[k] = '0;
      for (int k = 0; k < 4; k++) din2[k] = '0;

      repeat (2) @(negedge clk);
      chk("rst_valid", int'(ov), 0);
      chk("rst_sat", int'(sat), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out0", int'(aout[0]), 0);
      chk("rst_out63", int'(aout[63]), 0);
      rstn = 1'b1;

      group(3, 1'b0, 1'b0, 27, 1'b0);
      idle(1);
      chk("busy_after_final", int'(busy), 0);

      group(0, 1'b1, 1'b1, 9, 1'b0);
      idle(2);

      group(1, 1'b0, 1'b0, 9, 1'b0);
      group(-2, 1'b0, 1'b0, -18, 1'b0);
      idle(2);

      repeat (4) beat(5, 1'b0, 1'b0);
      chk("busy_mid_group", int'(busy), 1);
      beat(5, 1'b0, 1'b1);
      idle(1);
      chk("busy_after_clear", int'(busy), 0);
      group(1, 1'b0, 1'b0, 9, 1'b0);
      idle(2);

      repeat (4) beat(2, 1'b0, 1'b0);
      @(negedge clk);
      valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("arst_out0", int'(aout[0]), 0);
      chk("arst_out63", int'(aout[63]), 0);
      chk("arst_valid", int'(ov), 0);
      chk("arst_sat", int'(sat), 0);
      chk("arst_busy", int'(busy), 0);
      @(negedge clk);
      rstn = 1'b1;
      group(2, 1'b0, 1'b0, 18, 1'b0);
      idle(4);
      chk("hold_out10", int'(aout[10]), 18);
      chk("hold_sat", int'(sat), 0);

      group2(127, -1, 255, -9, 1'b1);
      group2(0, 0, 0, 0, 1'b0);
      idle(1);

      for (int i = 0; i < 20; i++) begin
         if (qb.size() == 0 && q2a.size() == 0) break;
         @(negedge clk);
      end
      chk("queue_drained", qb.size() + q2a.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
